lc3_mem_responder: RTL
======================

// Module: lc3_mem_responder
// PURPOSE
// - Responder side of the LC3 instruction/data memory protocol: serves the core's fetch (pc/instrmem_rd) and data (Data_addr/Data_din/Data_rd) requests.
// - Returns Instr_dout/Data_dout with complete_instr/complete_data after a programmable wait latency.
// - Sits between the LC3 core and the testbench as a synthesizable memory model; holds two 16-bit word arrays, IMEM and DMEM.
// PARAMETERS
// - AW         8   address bits used per array (depth 2**AW words; upper pc/Data_addr bits ignored, address wraps)
// - INSTR_LAT  2   wait cycles between an accepted fetch and complete_instr (0..15)
// - DATA_LAT   3   wait cycles between an accepted data access and complete_data (0..15)
// PORTS
// - clock           input   1   single clock, all logic on posedge
// - reset           input   1   asynchronous, active-low reset
// - pc              input   16  fetch address
// - instrmem_rd     input   1   fetch request strobe, sampled high = request
// - Instr_dout      output  16  fetched instruction, valid while complete_instr=1
// - complete_instr  output  1   one-cycle fetch completion pulse
// - Data_req        input   1   data access request strobe
// - Data_rd         input   1   1 = read, 0 = write (sampled with Data_req)
// - Data_addr       input   16  data address
// - Data_din        input   16  write data from core
// - Data_dout       output  16  read data, valid while complete_data=1
// - complete_data   output  1   one-cycle data completion pulse (reads and writes)
// - ld_en           input   1   back-door preload write enable
// - ld_sel          input   1   0 = IMEM, 1 = DMEM
// - ld_addr         input   AW  preload address
// - ld_data         input   16  preload data
// BEHAVIOUR
// - Reset (reset=0, async): Instr_dout=0, Data_dout=0, complete_instr=0, complete_data=0, both FSMs IDLE, counters 0. Array contents are not reset.
// - Fetch FSM, states IDLE -> WAIT -> DONE -> IDLE:
//   - IDLE: instrmem_rd=1 at edge T latches pc[AW-1:0] and loads cnt=INSTR_LAT. Next state is WAIT, or DONE if INSTR_LAT=0.
//   - WAIT: cnt decrements each edge; moves to DONE when cnt reaches 1.
//   - DONE: complete_instr=1 and Instr_dout=IMEM[latched addr] for exactly one cycle, then IDLE.
//   - Net latency: request sampled at edge T, complete visible after edge T+1+INSTR_LAT.
//   - instrmem_rd while WAIT/DONE is ignored (no queue). A new request is accepted only in IDLE; the earliest is the cycle after DONE.
// - Data FSM: identical state structure, driven by Data_req/DATA_LAT.
//   - Latches Data_addr[AW-1:0], Data_rd and Data_din at acceptance.
//   - Read: Data_dout=DMEM[addr], sampled at the DONE edge.
//   - Write: DMEM[addr] <= latched Data_din on entry to DONE; Data_dout holds its previous value; complete_data still pulses.
// - Instr_dout and Data_dout keep their last value after the completion pulse (no return to 0).
// - Fetch and data FSMs are fully independent; both may complete on the same cycle.
// - Preload: ld_en=1 writes ld_data to the selected array at that edge, in any state.
//   - If a DMEM functional write and a preload hit the same address on the same edge, the functional write wins.
//   - A read completing on the same edge as a write to the same address returns the old data.
// - Reset mid-operation aborts any access: no completion pulse, a pending write is dropped, FSMs return to IDLE.
// - Addresses >= 2**AW wrap: 16'h0105 with AW=8 accesses word 8'h05.
// TESTING
// - Preload IMEM[3]=16'h1234, fetch pc=3 (INSTR_LAT=2) -> complete_instr high exactly on 3rd cycle after request, Instr_dout=16'h1234, one cycle wide.
// - Data write addr=8'h10, din=16'hBEEF, then read addr=8'h10 -> both complete after DATA_LAT+1 cycles; read Data_dout=16'hBEEF; Data_dout unchanged by the write.
// - Fetch and data requests on the same edge with INSTR_LAT=DATA_LAT=1 -> both pulses on the same cycle with correct data each.
// - instrmem_rd held high for 6 cycles, INSTR_LAT=2 -> exactly 2 completions, each 3 cycles after its accepting edge.
// - Write issued, reset asserted during WAIT -> no complete_data, outputs 0, DMEM word unchanged.
// - pc=16'hFF05, AW=8 -> returns IMEM[8'h05]; INSTR_LAT=0 -> complete_instr on the very next cycle.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// Synthesizable LC3 memory responder: independent fetch and data channels, each
// answering after a fixed wait latency from its own IMEM / DMEM word array.
module lc3_mem_responder #(
    parameter int AW        = 8,
    parameter int INSTR_LAT = 2,
    parameter int DATA_LAT  = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [15:0]   pc,
    input  logic          instrmem_rd,
    output logic [15:0]   Instr_dout,
    output logic          complete_instr,
    input  logic          Data_req,
    input  logic          Data_rd,
    input  logic [15:0]   Data_addr,
    input  logic [15:0]   Data_din,
    output logic [15:0]   Data_dout,
    output logic          complete_data,
    input  logic          ld_en,
    input  logic          ld_sel,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] ILAT = 4'(INSTR_LAT);
    localparam logic [3:0] DLAT = 4'(DATA_LAT);

    logic [15:0] imem [2**AW];
    logic [15:0] dmem [2**AW];

    // Upper address bits are intentionally dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc[15:AW], Data_addr[15:AW]};

    // ---------------- fetch channel ----------------
    state_t        i_state_q, i_state_d;
    logic [3:0]    i_cnt_q, i_cnt_d;
    logic [AW-1:0] i_addr_q, i_addr_d;
    logic [15:0]   i_dout_q;
    logic          i_done_q;

    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_addr_d  = i_addr_q;
        case (i_state_q)
            IDLE: begin
                if (instrmem_rd) begin
                    i_addr_d  = pc[AW-1:0];
                    i_cnt_d   = ILAT;
                    i_state_d = (ILAT == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                i_cnt_d = i_cnt_q - 4'd1;
                if (i_cnt_q <= 4'd1) i_state_d = DONE;
            end
            DONE:    i_state_d = IDLE;
            default: i_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_state_q <= IDLE;
            i_cnt_q   <= 4'd0;
            i_addr_q  <= '0;
            i_dout_q  <= 16'd0;
            i_done_q  <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_addr_q  <= i_addr_d;
            i_done_q  <= (i_state_q == DONE);
            if (i_state_q == DONE) i_dout_q <= imem[i_addr_q];
        end
    end

    // ---------------- data channel ----------------
    state_t        d_state_q, d_state_d;
    logic [3:0]    d_cnt_q, d_cnt_d;
    logic [AW-1:0] d_addr_q, d_addr_d;
    logic          d_rd_q, d_rd_d;
    logic [15:0]   d_din_q, d_din_d;
    logic [15:0]   d_dout_q;
    logic          d_done_q;
    logic          d_we;

    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_addr_d  = d_addr_q;
        d_rd_d    = d_rd_q;
        d_din_d   = d_din_q;
        case (d_state_q)
            IDLE: begin
                if (Data_req) begin
                    d_addr_d  = Data_addr[AW-1:0];
                    d_rd_d    = Data_rd;
                    d_din_d   = Data_din;
                    d_cnt_d   = DLAT;
                    d_state_d = (DLAT == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                d_cnt_d = d_cnt_q - 4'd1;
                if (d_cnt_q <= 4'd1) d_state_d = DONE;
            end
            DONE:    d_state_d = IDLE;
            default: d_state_d = IDLE;
        endcase
    end

    // The write commits on the edge that enters DONE; the _d values already
    // carry the freshly latched request when the latency is zero.
    assign d_we = reset && !d_rd_d && (d_state_q != DONE) && (d_state_d == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_state_q <= IDLE;
            d_cnt_q   <= 4'd0;
            d_addr_q  <= '0;
            d_rd_q    <= 1'b0;
            d_din_q   <= 16'd0;
            d_dout_q  <= 16'd0;
            d_done_q  <= 1'b0;
        end else begin
            d_state_q <= d_state_d;
            d_cnt_q   <= d_cnt_d;
            d_addr_q  <= d_addr_d;
            d_rd_q    <= d_rd_d;
            d_din_q   <= d_din_d;
            d_done_q  <= (d_state_q == DONE);
            if (d_state_q == DONE && d_rd_q) d_dout_q <= dmem[d_addr_q];
        end
    end

    // Functional DMEM write is placed last so it overrides a same-address preload.
    always_ff @(posedge clock) begin
        if (ld_en && !ld_sel) imem[ld_addr] <= ld_data;
        if (ld_en && ld_sel)  dmem[ld_addr] <= ld_data;
        if (d_we)             dmem[d_addr_d] <= d_din_d;
    end

    assign Instr_dout     = i_dout_q;
    assign complete_instr = i_done_q;
    assign Data_dout      = d_dout_q;
    assign complete_data  = d_done_q;

endmodule
